irq_pulse_collector: RTL and testbench
======================================

// Module: irq_pulse_collector
// PURPOSE
//   Downstream of the timer interrupt pulse generator. Converts its 15 periodic
//   interrupt pulse lines into sticky, maskable pending bits for MicroBlaze.
//   Provides one level interrupt, a lowest-index-first vector, write-1-to-clear
//   acknowledge, and per-channel overrun flags plus a lost-event counter.
// PARAMETERS
//   CH_NUM  15  number of interrupt pulse channels
//   CNT_W   16  width of the saturating lost-event counter
// PORTS
//   clk_100      in   1       100 MHz system clock
//   rst_100_n    in   1       asynchronous reset, active-low
//   irq_pulse    in   CH_NUM  interrupt pulses, synchronous to clk_100, any width >= 1 cycle
//   irq_mask     in   CH_NUM  1 = channel enabled to drive irq_out; applied combinationally to next state
//   ack_valid    in   1       acknowledge strobe, single cycle
//   ack_bits     in   CH_NUM  write-1-to-clear select, sampled when ack_valid=1
//   irq_pend     out  CH_NUM  sticky pending bits (unmasked view)
//   irq_ovr      out  CH_NUM  overrun: a new edge arrived while pending was already 1
//   irq_out      out  1       level interrupt = |(irq_pend & irq_mask), registered
//   irq_id       out  4       index of lowest-numbered pending & enabled channel
//   irq_id_vld   out  1       1 when irq_id is meaningful (equals irq_out)
//   lost_cnt     out  CNT_W   count of overrun events, saturating
// BEHAVIOUR
// - Asynchronous reset (rst_100_n=0): irq_pend, irq_ovr, irq_out, irq_id, irq_id_vld,
//   lost_cnt and the internal delayed-pulse register pulse_d all go to 0.
// - Edge detect: edge[i] = irq_pulse[i] & ~pulse_d[i]; pulse_d <= irq_pulse every cycle.
//   A pulse held high across reset release counts as one edge on the first cycle.
//   Pulse width is irrelevant; only the rising edge counts.
// - Per channel, per cycle (clr = ack_valid & ack_bits[i]):
//     edge & ~pend          -> pend<=1, ovr unchanged
//     edge & pend & ~clr    -> pend stays 1, ovr<=1, lost event
//     edge & clr            -> pend<=1, ovr<=0 (set wins over clear; no lost event)
//     ~edge & clr           -> pend<=0, ovr<=0
//     otherwise             -> hold
// - lost_cnt increments by the number of channels with a lost event this cycle
//   (0..CH_NUM) and saturates at 2^CNT_W-1; it is never cleared except by reset.
//   The adder is CNT_W+1 bits wide; clamp on overflow.
// - Masking does not block latching: masked channels still set pend and ovr.
// - irq_out, irq_id and irq_id_vld are registered from the next-state pend & irq_mask,
//   so they update on the same edge as irq_pend. Latency: rising irq_pulse sampled at
//   clock edge k -> irq_pend[i] and irq_out high after edge k.
// - irq_id: priority encode, bit 0 highest priority. When nothing is enabled and
//   pending: irq_id=0 and irq_id_vld=0.
// - Acknowledging a non-pending channel is harmless; ack_bits is ignored when ack_valid=0.
// - A mask change takes effect on irq_out at the next clock edge. Pending state is
//   unaffected by the mask change.
// - Reset mid-operation: all pending, overrun and count state is discarded
//   immediately (asynchronous). No events are replayed after reset.
// TESTING
// - Reset: hold rst_100_n=0 with irq_pulse=15'h7FFF, then release -> first cycle sets
//   irq_pend=15'h7FFF; all outputs are 0 while in reset.
// - Single event: mask=15'h0004, a 100-cycle pulse on ch2 -> irq_pend=15'h0004,
//   irq_out=1 and irq_id=2 after the first edge. The state is held after the pulse
//   falls. ack_valid with ack_bits=15'h0004 -> all outputs clear on the next edge.
// - Priority and mask: pulses on ch3 and ch9 with mask=15'h7FFF -> irq_id=3.
//   Set mask=15'h7FF7 -> irq_id=9 next cycle. Set mask=0 -> irq_out=0, irq_pend=15'h0208.
// - Overrun: two ch0 edges 10000 cycles apart with no ack -> irq_ovr[0]=1, lost_cnt=1.
//   Simultaneous overrun edges on ch0..ch4 in one cycle -> lost_cnt increases by 5.
// - Set/clear collision: ch5 edge in the same cycle as ack_bits[5]=1 while pending ->
//   irq_pend[5]=1, irq_ovr[5]=0, lost_cnt unchanged.
// - Saturation: with CNT_W=4, force 20 overruns -> lost_cnt stops at 15 and does not wrap.

Source files
------------

// File: rtl/irq_pulse_collector.sv
// irq_pulse_collector: turns periodic interrupt pulses into sticky, maskable
// pending bits with overrun tracking, a lowest-index-first vector and a
// saturating lost-event counter.
module irq_pulse_collector #(
   parameter int unsigned CH_NUM = 15,
   parameter int unsigned CNT_W  = 16
) (
   input  logic              clk_100,
   input  logic              rst_100_n,
   input  logic [CH_NUM-1:0] irq_pulse,
   input  logic [CH_NUM-1:0] irq_mask,
   input  logic              ack_valid,
   input  logic [CH_NUM-1:0] ack_bits,
   output logic [CH_NUM-1:0] irq_pend,
   output logic [CH_NUM-1:0] irq_ovr,
   output logic              irq_out,
   output logic [3:0]        irq_id,
   output logic              irq_id_vld,
   output logic [CNT_W-1:0]  lost_cnt
);

   localparam int unsigned SUM_W = $clog2(CH_NUM + 1);
   localparam int unsigned ADD_W = CNT_W + 1;

   logic [CH_NUM-1:0] pulse_q;
   logic [CH_NUM-1:0] pend_q, pend_d;
   logic [CH_NUM-1:0] ovr_q, ovr_d;
   logic [CH_NUM-1:0] edge_det, clr, lost, enabled;
   logic [SUM_W-1:0]  lost_num;
   logic [ADD_W-1:0]  cnt_sum;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic              out_q, out_d;
   logic [3:0]        id_q, id_d;

   // Per-channel edge detect and set/clear resolution; a new edge beats a clear.
   always_comb begin
      edge_det = irq_pulse & ~pulse_q;
      clr      = {CH_NUM{ack_valid}} & ack_bits;
      lost     = edge_det & pend_q & ~clr;
      pend_d   = edge_det | (pend_q & ~clr);
      ovr_d    = lost | (ovr_q & ~clr);
   end

   // Count lost events this cycle and add them to the counter, clamping at all-ones.
   always_comb begin
      lost_num = '0;
      for (int i = 0; i < CH_NUM; i++) begin
         lost_num = lost_num + SUM_W'(lost[i]);
      end
      cnt_sum = {1'b0, cnt_q} + ADD_W'(lost_num);
      cnt_d   = cnt_sum[CNT_W] ? {CNT_W{1'b1}} : cnt_sum[CNT_W-1:0];
   end

   // Priority encode from next-state pending so the vector moves with irq_pend.
   always_comb begin
      enabled = pend_d & irq_mask;
      out_d   = |enabled;
      id_d    = '0;
      for (int i = CH_NUM - 1; i >= 0; i--) begin
         if (enabled[i]) begin
            id_d = 4'(i);
         end
      end
   end

   // State registers; reset discards all pending, overrun and count state.
   always_ff @(posedge clk_100 or negedge rst_100_n) begin
      if (!rst_100_n) begin
         pulse_q <= '0;
         pend_q  <= '0;
         ovr_q   <= '0;
         cnt_q   <= '0;
         out_q   <= 1'b0;
         id_q    <= '0;
      end else begin
         pulse_q <= irq_pulse;
         pend_q  <= pend_d;
         ovr_q   <= ovr_d;
         cnt_q   <= cnt_d;
         out_q   <= out_d;
         id_q    <= id_d;
      end
   end

   assign irq_pend   = pend_q;
   assign irq_ovr    = ovr_q;
   assign irq_out    = out_q;
   assign irq_id     = id_q;
   assign irq_id_vld = out_q;
   assign lost_cnt   = cnt_q;

endmodule

// File: tb/tb_irq_pulse_collector.sv
// Scoreboard bench for irq_pulse_collector: the driver queues hand-computed
// expectations tagged with the cycle they are due; a monitor checks them.
module tb_irq_pulse_collector;

   logic        clk = 1'b0;
   logic        rst_n;
   logic [14:0] pulse, mask, ack_bits;
   logic        ack_valid;

   logic [14:0] pend, ovr, pend4, ovr4;
   logic        out, vld, out4, vld4;
   logic [3:0]  id, id4;
   logic [15:0] cnt;
   logic [3:0]  cnt4;

   int cyc  = 0;
   int cmps = 0;
   int errs = 0;

   typedef struct {
      string       name;
      int          tgt;
      logic [14:0] pend;
      logic [14:0] ovr;
      logic        out;
      logic [3:0]  id;
      logic [15:0] cnt;
      logic [3:0]  cnt4;
   } exp_t;

   exp_t sb[$];
   exp_t e;

   irq_pulse_collector #(.CH_NUM(15), .CNT_W(16)) dut (
      .clk_100(clk), .rst_100_n(rst_n), .irq_pulse(pulse), .irq_mask(mask),
      .ack_valid(ack_valid), .ack_bits(ack_bits), .irq_pend(pend), .irq_ovr(ovr),
      .irq_out(out), .irq_id(id), .irq_id_vld(vld), .lost_cnt(cnt)
   );

   irq_pulse_collector #(.CH_NUM(15), .CNT_W(4)) dut4 (
      .clk_100(clk), .rst_100_n(rst_n), .irq_pulse(pulse), .irq_mask(mask),
      .ack_valid(ack_valid), .ack_bits(ack_bits), .irq_pend(pend4), .irq_ovr(ovr4),
      .irq_out(out4), .irq_id(id4), .irq_id_vld(vld4), .lost_cnt(cnt4)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   // Monitor: compare every expectation that is due this cycle.
   always @(negedge clk) begin
      while (sb.size() > 0 && sb[0].tgt <= cyc) begin
         e = sb.pop_front();
         cmps++;
         if (e.tgt < cyc) begin
            errs++;
            $display("FAIL %s: expectation missed, due cycle %0d, now %0d", e.name, e.tgt, cyc);
         end else if (pend !== e.pend || ovr !== e.ovr || out !== e.out || vld !== e.out ||
                      id !== e.id || cnt !== e.cnt || cnt4 !== e.cnt4 || pend4 !== e.pend ||
                      out4 !== e.out || id4 !== e.id) begin
            errs++;
            $display("FAIL %s: got pend=%h ovr=%h out=%b vld=%b id=%0d cnt=%0d cnt4=%0d pend4=%h, want pend=%h ovr=%h out=%b vld=%b id=%0d cnt=%0d cnt4=%0d",
                     e.name, pend, ovr, out, vld, id, cnt, cnt4, pend4,
                     e.pend, e.ovr, e.out, e.out, e.id, e.cnt, e.cnt4);
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Queue an expectation due dly cycles from now (0 = before the next edge).
   task automatic exp_push(input string nm, input logic [14:0] p, input logic [14:0] o,
                           input logic ou, input logic [3:0] i, input logic [15:0] c,
                           input logic [3:0] c4, input int dly);
      exp_t x;
      x.name = nm;
      x.tgt  = cyc + dly;
      x.pend = p;
      x.ovr  = o;
      x.out  = ou;
      x.id   = i;
      x.cnt  = c;
      x.cnt4 = c4;
      sb.push_back(x);
   endtask

   initial begin
      rst_n     = 1'b0;
      pulse     = 15'h7FFF;
      mask      = '0;
      ack_valid = 1'b0;
      ack_bits  = '0;
      tick();
      tick();

      // Reset and release with all pulses already high
      exp_push("reset_hold", 15'h0000, 15'h0000, 1'b0, 4'd0, 16'd0, 4'd0, 1);
      tick();
      rst_n = 1'b1;
      exp_push("reset_release", 15'h7FFF, 15'h0000, 1'b0, 4'd0, 16'd0, 4'd0, 1);
      tick();
      pulse = '0;
      exp_push("held_no_edge", 15'h7FFF, 15'h0000, 1'b0, 4'd0, 16'd0, 4'd0, 1);
      tick();
      ack_valid = 1'b1; ack_bits = 15'h7FFF;
      exp_push("ack_all", 15'h0000, 15'h0000, 1'b0, 4'd0, 16'd0, 4'd0, 1);
      tick();
      ack_valid = 1'b0; ack_bits = '0;

      // Single 100-cycle pulse on ch2
      mask = 15'h0004; pulse = 15'h0004;
      exp_push("single_set", 15'h0004, 15'h0000, 1'b1, 4'd2, 16'd0, 4'd0, 1);
      tick();
      repeat (99) tick();
      pulse = '0;
      exp_push("single_hold", 15'h0004, 15'h0000, 1'b1, 4'd2, 16'd0, 4'd0, 1);
      tick();
      ack_valid = 1'b1; ack_bits = 15'h0004;
      exp_push("single_ack", 15'h0000, 15'h0000, 1'b0, 4'd0, 16'd0, 4'd0, 1);
      tick();
      ack_valid = 1'b0; ack_bits = '0;

      // Priority and mask
      mask = 15'h7FFF; pulse = 15'h0208;
      exp_push("prio_both", 15'h0208, 15'h0000, 1'b1, 4'd3, 16'd0, 4'd0, 1);
      tick();
      pulse = '0; mask = 15'h7FF7;
      exp_push("prio_mask3", 15'h0208, 15'h0000, 1'b1, 4'd9, 16'd0, 4'd0, 1);
      tick();
      mask = '0;
      exp_push("prio_mask_all", 15'h0208, 15'h0000, 1'b0, 4'd0, 16'd0, 4'd0, 1);
      tick();
      ack_valid = 1'b1; ack_bits = 15'h0208;
      exp_push("prio_ack", 15'h0000, 15'h0000, 1'b0, 4'd0, 16'd0, 4'd0, 1);
      tick();
      ack_valid = 1'b0; ack_bits = '0; mask = 15'h7FFF;

      // Overrun: two ch0 edges 10000 cycles apart
      pulse = 15'h0001;
      exp_push("ovr_first", 15'h0001, 15'h0000, 1'b1, 4'd0, 16'd0, 4'd0, 1);
      tick();
      pulse = '0;
      repeat (9999) tick();
      pulse = 15'h0001;
      exp_push("ovr_second", 15'h0001, 15'h0001, 1'b1, 4'd0, 16'd1, 4'd1, 1);
      tick();
      pulse = '0; tick();
      pulse = 15'h001E;
      exp_push("ovr_fill", 15'h001F, 15'h0001, 1'b1, 4'd0, 16'd1, 4'd1, 1);
      tick();
      pulse = '0; tick();
      pulse = 15'h001F;
      exp_push("ovr_five", 15'h001F, 15'h001F, 1'b1, 4'd0, 16'd6, 4'd6, 1);
      tick();
      pulse = '0; tick();

      // Set/clear collision on ch5, with its overrun flag set beforehand
      pulse = 15'h0020;
      exp_push("coll_set5", 15'h003F, 15'h001F, 1'b1, 4'd0, 16'd6, 4'd6, 1);
      tick();
      pulse = '0; tick();
      pulse = 15'h0020;
      exp_push("coll_ovr5", 15'h003F, 15'h003F, 1'b1, 4'd0, 16'd7, 4'd7, 1);
      tick();
      pulse = '0; tick();
      pulse = 15'h0020; ack_valid = 1'b1; ack_bits = 15'h0020;
      exp_push("coll_same", 15'h003F, 15'h001F, 1'b1, 4'd0, 16'd7, 4'd7, 1);
      tick();
      pulse = '0; ack_valid = 1'b0; ack_bits = 15'h7FFF;
      exp_push("ack_ignored", 15'h003F, 15'h001F, 1'b1, 4'd0, 16'd7, 4'd7, 1);
      tick();
      ack_valid = 1'b1;
      exp_push("ack_clear_all", 15'h0000, 15'h0000, 1'b0, 4'd0, 16'd7, 4'd7, 1);
      tick();
      ack_valid = 1'b0; ack_bits = '0;

      // Saturation of the 4-bit counter, 16-bit one keeps counting
      pulse = 15'h0001;
      exp_push("sat_arm", 15'h0001, 15'h0000, 1'b1, 4'd0, 16'd7, 4'd7, 1);
      tick();
      pulse = '0; tick();
      for (int k = 1; k <= 20; k++) begin
         pulse = 15'h0001;
         exp_push($sformatf("sat_%0d", k), 15'h0001, 15'h0001, 1'b1, 4'd0, 16'(7 + k),
                  (7 + k > 15) ? 4'd15 : 4'(7 + k), 1);
         tick();
         pulse = '0; tick();
      end
      pulse = 15'h7FFE;
      exp_push("sat_multi_arm", 15'h7FFF, 15'h0001, 1'b1, 4'd0, 16'd27, 4'd15, 1);
      tick();
      pulse = '0; tick();
      pulse = 15'h7FFF;
      exp_push("sat_multi", 15'h7FFF, 15'h7FFF, 1'b1, 4'd0, 16'd42, 4'd15, 1);
      tick();
      pulse = '0; tick();

      // Asynchronous reset mid-operation, then no replay after release
      rst_n = 1'b0;
      exp_push("async_reset", 15'h0000, 15'h0000, 1'b0, 4'd0, 16'd0, 4'd0, 0);
      tick();
      rst_n = 1'b1;
      exp_push("no_replay", 15'h0000, 15'h0000, 1'b0, 4'd0, 16'd0, 4'd0, 1);
      tick();
      tick();
      tick();

      cmps++;
      if (sb.size() != 0) begin
         errs++;
         $display("FAIL drain: %0d expectations left unchecked, want 0", sb.size());
      end
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmps, errs);
      $finish;
   end

endmodule
